// File: rtl/uart_echo_if.sv
// Handshake bundle between the uart core and uart_echo_responder.
// slave = the responder side, master = the uart/bench side.
interface uart_echo_if #(
    parameter int AW = 3
);
    logic          rx_rdy;
    logic [7:0]    rx_dout;
    logic          rx_rdy_clr;
    logic [7:0]    tx_din;
    logic          tx_wr_en;
    logic          tx_busy;
    logic [AW:0]   fifo_count;
    logic          overflow;

    modport slave (
        input  rx_rdy, rx_dout, tx_busy,
        output rx_rdy_clr, tx_din, tx_wr_en, fifo_count, overflow
    );

    modport master (
        output rx_rdy, rx_dout, tx_busy,
        input  rx_rdy_clr, tx_din, tx_wr_en, fifo_count, overflow
    );
endinterface

// File: rtl/uart_echo_responder.sv
// Byte-echo target: drains the uart receiver into a small FIFO and replays each byte
// through the uart transmitter. Define ECHO_UPCASE_EN to upper-case 'a'..'z' on the way out.
module uart_echo_responder #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    uart_echo_if.slave bus
);

    if (DEPTH < 2 || DEPTH != (1 << AW)) begin : g_param_check
        $error("DEPTH must be a power of two >= 2 and equal 2**AW");
    end

    typedef enum logic {RX_IDLE, RX_WAIT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    rx_state_t         rx_state_q, rx_state_d;
    tx_state_t         tx_state_q, tx_state_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              rx_rdy_clr_q, rx_rdy_clr_d;
    logic              tx_wr_en_q, tx_wr_en_d;
    logic [7:0]        tx_din_q, tx_din_d;
    logic [1:0]        to_cnt_q, to_cnt_d;
    logic              push, pop, full, empty;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    function automatic logic [7:0] echo_map(input logic [7:0] b);
`ifdef ECHO_UPCASE_EN
        return (b >= 8'h61 && b <= 8'h7A) ? (b - 8'h20) : b;
`else
        return b;
`endif
    endfunction

    // Receive side: one push (or one drop) per rdy assertion, however long rdy stays high.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        rx_state_d   = rx_state_q;
        rx_rdy_clr_d = 1'b0;
        overflow_d   = overflow_q;
        push         = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (bus.rx_rdy) begin
                    rx_rdy_clr_d = 1'b1;
                    if (!full) push       = 1'b1;
                    else       overflow_d = 1'b1;
                    rx_state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (!bus.rx_rdy) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Transmit side: launch only into an idle uart; a busy that never rises times out after 4 cycles.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_wr_en_d = 1'b0;
        tx_din_d   = tx_din_q;
        to_cnt_d   = to_cnt_q;
        pop        = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (!empty && !bus.tx_busy) begin
                    tx_din_d   = echo_map(mem_q[rd_ptr_q]);
                    tx_wr_en_d = 1'b1;
                    pop        = 1'b1;
                    to_cnt_d   = '0;
                    tx_state_d = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (bus.tx_busy)            tx_state_d = TX_WAIT_DONE;
                else if (to_cnt_q == 2'd3)  tx_state_d = TX_IDLE;
                else                        to_cnt_d   = to_cnt_q + 2'd1;
            end
            TX_WAIT_DONE: begin
                if (!bus.tx_busy) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // FIFO bookkeeping; full already suppressed the push, so push+pop never overfills.
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = bus.rx_dout;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q   <= RX_IDLE;
            tx_state_q   <= TX_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            rx_rdy_clr_q <= 1'b0;
            tx_wr_en_q   <= 1'b0;
            tx_din_q     <= 8'h00;
            to_cnt_q     <= '0;
        end else begin
            rx_state_q   <= rx_state_d;
            tx_state_q   <= tx_state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            rx_rdy_clr_q <= rx_rdy_clr_d;
            tx_wr_en_q   <= tx_wr_en_d;
            tx_din_q     <= tx_din_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    // NOTE: storage is cleared too, so nothing from before a reset can ever reach tx_din.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bus.rx_rdy_clr = rx_rdy_clr_q;
    assign bus.tx_wr_en   = tx_wr_en_q;
    assign bus.tx_din     = tx_din_q;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Scoreboard bench for uart_echo_responder: stimulus pushes expected tx bytes, a monitor
// pops and compares on every tx_wr_en pulse. A small counter stands in for the uart tx_busy.
module tb_uart_echo_responder;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk_50m = 1'b0;
    logic rst_n   = 1'b0;

    uart_echo_if #(.AW(AW)) bus ();

    uart_echo_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .bus     (bus.slave)
    );

    always #10 clk_50m = ~clk_50m;

    int         checks    = 0;
    int         errors    = 0;
    int         wr_count  = 0;
    int         clr_count = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    logic       busy_force = 1'b0;
    int         busy_cnt;

    // uart transmitter stand-in: busy for 10 cycles after each wr_en
    always @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n)             busy_cnt <= 0;
        else if (bus.tx_wr_en)  busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign bus.tx_busy = busy_force | (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk_50m) begin
        if (rst_n) begin
            if (bus.rx_rdy_clr) clr_count++;
            if (bus.tx_wr_en) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte %02h required no transmission", bus.tx_din);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("tx_din", {24'h0, bus.tx_din}, {24'h0, exp_b});
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic [7:0] eb, input bit expect_tx,
                             input int hold);
        bit seen;
        seen = 1'b0;
        if (expect_tx) exp_q.push_back(eb);
        @(negedge clk_50m);
        bus.rx_rdy  = 1'b1;
        bus.rx_dout = b;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_50m);
            if (bus.rx_rdy_clr) seen = 1'b1;
        end
        if (!seen) check("rdy_clr_timeout", 32'd0, 32'd1);
        repeat (hold) @(negedge clk_50m);
        bus.rx_rdy = 1'b0;
        @(negedge clk_50m);
    endtask

    task automatic wait_tx(input int target);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk_50m);
            if (wr_count >= target) done = 1'b1;
        end
        if (!done) check("tx_timeout", wr_count, target);
        repeat (15) @(negedge clk_50m);
    endtask

    int w0, c0;

    initial begin
        bus.rx_rdy  = 1'b0;
        bus.rx_dout = 8'h00;

        // Reset and idle
        repeat (5) @(negedge clk_50m);
        check("rst_rdy_clr",  bus.rx_rdy_clr, 1'b0);
        check("rst_wr_en",    bus.tx_wr_en,   1'b0);
        check("rst_tx_din",   bus.tx_din,     8'h00);
        check("rst_count",    bus.fifo_count, 4'd0);
        check("rst_overflow", bus.overflow,   1'b0);
        rst_n = 1'b1;
        w0 = wr_count; c0 = clr_count;
        repeat (100) @(negedge clk_50m);
        check("idle_no_tx",  wr_count - w0,  0);
        check("idle_no_clr", clr_count - c0, 0);

        // Single echo
        w0 = wr_count; c0 = clr_count;
        send_byte(8'hA5, 8'hA5, 1'b1, 0);
        wait_tx(w0 + 1);
        check("single_clr_pulses", clr_count - c0, 1);
        check("single_tx_pulses",  wr_count - w0,  1);
        check("single_count",      bus.fifo_count, 4'd0);

        // Burst into a stalled transmitter, then overflow
        busy_force = 1'b1;
        w0 = wr_count;
        for (int i = 0; i < 8; i++) send_byte(8'(i), 8'(i), 1'b1, 0);
        check("burst_count",    bus.fifo_count, 4'd8);
        check("burst_overflow", bus.overflow,   1'b0);
        send_byte(8'h08, 8'h08, 1'b0, 0);
        check("ovf_flag",  bus.overflow,   1'b1);
        check("ovf_count", bus.fifo_count, 4'd8);
        busy_force = 1'b0;
        wait_tx(w0 + 8);
        check("burst_drain_count", bus.fifo_count, 4'd0);
        check("burst_drain_tx",    wr_count - w0,  8);
        check("burst_sb_empty",    exp_q.size(),   0);

        // Held rdy: one push only
        busy_force = 1'b1;
        w0 = wr_count; c0 = clr_count;
        send_byte(8'h3C, 8'h3C, 1'b1, 10);
        check("held_count", bus.fifo_count, 4'd1);
        check("held_clr",   clr_count - c0, 1);
        busy_force = 1'b0;
        wait_tx(w0 + 1);
        check("held_tx", wr_count - w0, 1);

        // Async reset while in TX_WAIT_DONE with 3 bytes queued
        busy_force = 1'b1;
        send_byte(8'h11, 8'h11, 1'b1, 0);
        send_byte(8'h22, 8'h22, 1'b0, 0);
        send_byte(8'h33, 8'h33, 1'b0, 0);
        send_byte(8'h44, 8'h44, 1'b0, 0);
        w0 = wr_count;
        busy_force = 1'b0;
        for (int i = 0; i < 20 && wr_count == w0; i++) @(negedge clk_50m);
        repeat (3) @(negedge clk_50m);
        check("pre_rst_count", bus.fifo_count, 4'd3);
        check("pre_rst_busy",  bus.tx_busy,    1'b1);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_count",    bus.fifo_count, 4'd0);
        check("mid_rst_wr_en",    bus.tx_wr_en,   1'b0);
        check("mid_rst_overflow", bus.overflow,   1'b0);
        repeat (5) @(negedge clk_50m);
        rst_n = 1'b1;
        w0 = wr_count;
        repeat (100) @(negedge clk_50m);
        check("post_rst_no_echo", wr_count - w0, 0);
        check("post_rst_sb",      exp_q.size(),  0);

        // Case mapping
        w0 = wr_count;
`ifdef ECHO_UPCASE_EN
        send_byte(8'h61, 8'h41, 1'b1, 0);
`else
        send_byte(8'h61, 8'h61, 1'b1, 0);
`endif
        send_byte(8'h7B, 8'h7B, 1'b1, 0);
        send_byte(8'h41, 8'h41, 1'b1, 0);
        wait_tx(w0 + 3);
        check("case_tx",    wr_count - w0,  3);
        check("case_sb",    exp_q.size(),   0);
        check("case_count", bus.fifo_count, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
